// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths, word-address offset and FSM state type.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;
    localparam int ADDR_LSB   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        READY
    } apb_state_t;

    // Counter width able to hold the wait-state count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB completer-side bus bundle with master and slave views.
interface apb_slave_regs_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output pselx,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  pready,
        input  prdata,
        input  pslverr
    );

    modport slave (
        input  pselx,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output pready,
        output prdata,
        output pslverr
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that flags the last wait state of an APB access.
module apb_wait_ctr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // done marks the cycle in which pready must be scheduled for the next cycle.
    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave register bank with a fixed number of wait states; register 0 drives ctrl_o.
// Optional APB_SLV_ERR_EN: flag out-of-range accesses with pslverr.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    apb_slave_regs_if.slave   bus,
    output logic [DATA_W-1:0] ctrl_o
);

    localparam int IDX_W = ADDR_W - ADDR_LSB;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    apb_state_t        state;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_write;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              pready_r;
    logic [DATA_W-1:0] prdata_r;
    logic              pslverr_r;

    logic              start;
    logic              access;
    logic [IDX_W-1:0]  live_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_is_write;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_value;
    logic              err_next;
    logic              cap_in_range;
    logic              commit;
    logic              ctr_load;
    logic              ctr_dec;
    logic              ctr_done;
    logic              unused_addr_lsb;

    assign start    = bus.pselx && !bus.penable;
    assign access   = bus.pselx && bus.penable;
    assign live_idx = bus.paddr[ADDR_W-1:ADDR_LSB];
    assign unused_addr_lsb = ^bus.paddr[ADDR_LSB-1:0];

    // With zero wait states the response is built in IDLE from the live bus, otherwise from the captured copy.
    assign rd_idx      = (state == IDLE) ? live_idx  : cap_idx;
    assign rd_is_write = (state == IDLE) ? bus.pwrite : cap_write;
    assign rd_in_range = int'(rd_idx) < NUM_REGS;
    assign rd_value    = (rd_in_range && !rd_is_write) ? regs[rd_idx[SEL_W-1:0]] : '0;

`ifdef APB_SLV_ERR_EN
    assign err_next = !rd_in_range;
`else
    assign err_next = 1'b0;
`endif

    assign cap_in_range = int'(cap_idx) < NUM_REGS;
    assign commit       = (state == READY) && access && cap_write && cap_in_range;

    assign ctr_load = (state == IDLE) && start;
    assign ctr_dec  = ((state == SETUP) || (state == WAIT)) && access;

    apb_wait_ctr #(
        .WIDTH (CNT_W)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (ctr_dec),
        .done     (ctr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            pready_r  <= 1'b0;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            pready_r  <= 1'b0;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_idx   <= live_idx;
                        cap_write <= bus.pwrite;
                        cap_wdata <= bus.pwdata;
                        if (WAIT_CYCLES == 0) begin
                            state     <= READY;
                            pready_r  <= 1'b1;
                            prdata_r  <= rd_value;
                            pslverr_r <= err_next;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP, WAIT: begin
                    // Losing pselx (or penable) mid-access abandons the transfer without a write.
                    if (!access) begin
                        state <= IDLE;
                    end else if (ctr_done) begin
                        state     <= READY;
                        pready_r  <= 1'b1;
                        prdata_r  <= rd_value;
                        pslverr_r <= err_next;
                    end else begin
                        state <= WAIT;
                    end
                end
                READY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[cap_idx[SEL_W-1:0]] <= cap_wdata;
        end
    end

    assign bus.pready  = pready_r;
    assign bus.prdata  = prdata_r;
    assign bus.pslverr = pslverr_r;
    assign ctrl_o      = regs[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs at 0, 1 and 3 wait states.
module tb_apb_slave_regs;
    import apb_pkg::*;

`ifdef APB_SLV_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pselx = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    int          cur = 1;

    logic        m_pready;
    logic        m_pslverr;
    logic [31:0] m_prdata;
    logic [31:0] m_ctrl;
    logic [31:0] ctrl0, ctrl1, ctrl3;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    apb_slave_regs_if #(.ADDR_W(8), .DATA_W(32)) bus_w0 ();
    apb_slave_regs_if #(.ADDR_W(8), .DATA_W(32)) bus_w1 ();
    apb_slave_regs_if #(.ADDR_W(8), .DATA_W(32)) bus_w3 ();

    assign bus_w0.pselx   = pselx && (cur == 0);
    assign bus_w0.penable = penable;
    assign bus_w0.pwrite  = pwrite;
    assign bus_w0.paddr   = paddr;
    assign bus_w0.pwdata  = pwdata;
    assign bus_w1.pselx   = pselx && (cur == 1);
    assign bus_w1.penable = penable;
    assign bus_w1.pwrite  = pwrite;
    assign bus_w1.paddr   = paddr;
    assign bus_w1.pwdata  = pwdata;
    assign bus_w3.pselx   = pselx && (cur == 2);
    assign bus_w3.penable = penable;
    assign bus_w3.pwrite  = pwrite;
    assign bus_w3.paddr   = paddr;
    assign bus_w3.pwdata  = pwdata;

    apb_slave_regs #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus_w0), .ctrl_o(ctrl0));
    apb_slave_regs #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus_w1), .ctrl_o(ctrl1));
    apb_slave_regs #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus_w3), .ctrl_o(ctrl3));

    assign m_pready  = (cur == 0) ? bus_w0.pready  : (cur == 1) ? bus_w1.pready  : bus_w3.pready;
    assign m_pslverr = (cur == 0) ? bus_w0.pslverr : (cur == 1) ? bus_w1.pslverr : bus_w3.pslverr;
    assign m_prdata  = (cur == 0) ? bus_w0.prdata  : (cur == 1) ? bus_w1.prdata  : bus_w3.prdata;
    assign m_ctrl    = (cur == 0) ? ctrl0 : (cur == 1) ? ctrl1 : ctrl3;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d): got %h expected %h", name, cur, act, exp);
        end
    endtask

    // Monitor: a completing transfer pops the scoreboard; any other cycle must look idle.
    always @(negedge clk) begin
        if (rst) begin
            if (pselx && penable && m_pready) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_pready", 32'(m_pready), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    checkOutput("prdata", m_prdata, mon_e.rdata);
                    checkOutput("pslverr", 32'(m_pslverr), 32'(mon_e.err));
                end
            end else begin
                checkOutput("pready_idle", 32'(m_pready), 32'd0);
                checkOutput("prdata_idle", m_prdata, 32'd0);
                checkOutput("pslverr_idle", 32'(m_pslverr), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_rd, input logic exp_err,
                                 input int exp_lat, input bit b2b, input bit glitch);
        exp_t e;
        int   n;
        bit   got;
        e.rdata = exp_rd;
        e.err   = exp_err;
        q.push_back(e);
        pselx   = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge clk); #1;
        penable = 1'b1;
        n   = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            n++;
            @(negedge clk);
            got = m_pready;
            if (!got) begin
                @(posedge clk); #1;
                if (glitch) begin
                    paddr  = a ^ 8'h0C;
                    pwdata = ~d;
                end
            end
        end
        @(posedge clk); #1;
        checkOutput("latency", 32'(n), 32'(exp_lat));
        if (!got && q.size() > 0) void'(q.pop_front());
        if (!b2b) begin
            pselx   = 1'b0;
            penable = 1'b0;
        end
    endtask

    task automatic resetMidWrite();
        pselx   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h0C;
        pwdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_pready", 32'(m_pready), 32'd0);
        checkOutput("rst_mid_ctrl", m_ctrl, 32'd0);
        @(posedge clk); #1;
        pselx   = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            cur = c;
            #1;
            checkOutput("rst_pready", 32'(m_pready), 32'd0);
            checkOutput("rst_prdata", m_prdata, 32'd0);
            checkOutput("rst_pslverr", 32'(m_pslverr), 32'd0);
            checkOutput("rst_ctrl", m_ctrl, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        cur = 1;
        applyStimulus(1'b1, 8'h00, 32'hDEAD_BEEF, 32'd0, 1'b0, 3, 1'b0, 1'b0);
        checkOutput("ctrl_after_write", m_ctrl, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 8'h3C, 32'h1234_5678, 32'd0, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h3C, 32'd0, 32'h1234_5678, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 1'b0);

        resetMidWrite();
        checkOutput("ctrl_after_reset", m_ctrl, 32'd0);
        applyStimulus(1'b0, 8'h0C, 32'd0, 32'd0, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h3C, 32'd0, 32'd0, 1'b0, 3, 1'b0, 1'b0);

        pselx   = 1'b1;
        penable = 1'b1;
        paddr   = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("penable_no_setup", 32'(m_pready), 32'd0);
        end
        pselx   = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b1, 8'h07, 32'h0000_1111, 32'd0, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h04, 32'd0, 32'h0000_1111, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 32'hCAFE_0001, 32'd0, 1'b0, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h40, 32'h0000_0055, 32'd0, ERR_EN, 3, 1'b0, 1'b0);
        checkOutput("ctrl_oob_write", m_ctrl, 32'hCAFE_0001);
        applyStimulus(1'b0, 8'h40, 32'd0, 32'd0, ERR_EN, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 32'd0, 32'hCAFE_0001, 1'b0, 3, 1'b0, 1'b0);

        cur = 0;
        applyStimulus(1'b1, 8'h04, 32'h0404_0404, 32'd0, 1'b0, 2, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h08, 32'h0808_0808, 32'd0, 1'b0, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h04, 32'd0, 32'h0404_0404, 1'b0, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h08, 32'd0, 32'h0808_0808, 1'b0, 2, 1'b0, 1'b0);

        cur = 2;
        applyStimulus(1'b1, 8'h10, 32'h0000_0011, 32'd0, 1'b0, 5, 1'b0, 1'b0);
        pselx   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 32'h0000_00AA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        pselx   = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h10, 32'd0, 32'h0000_0011, 1'b0, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h14, 32'h0000_0099, 32'd0, 1'b0, 5, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h14, 32'd0, 32'h0000_0099, 1'b0, 5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h18, 32'd0, 32'd0, 1'b0, 5, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
